// File: rtl/cpu_pkg.sv
// Shared ISA constants for the 16-bit pipeline: opcodes, instruction field
// positions and the branch-history reset value.
package cpu_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_ADDI = 4'h4;
   localparam logic [3:0] OP_LD   = 4'h5;
   localparam logic [3:0] OP_ST   = 4'h6;
   localparam logic [3:0] OP_BEQ  = 4'h7;
   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam int OPC_HI = 15;
   localparam int OPC_LO = 12;
   localparam int FA_HI  = 11;
   localparam int FA_LO  = 8;
   localparam int FB_HI  = 7;
   localparam int FB_LO  = 4;
   localparam int FC_HI  = 3;
   localparam int FC_LO  = 0;

   localparam logic [1:0] BHT_RESET = 2'b01;

   function automatic logic signed [15:0] sext4(input logic [3:0] v);
      return $signed({{12{v[3]}}, v});
   endfunction

endpackage

// File: rtl/branch_predictor_bht.sv
// Table of 2-bit saturating branch counters with one combinational read port
// and one synchronous update port; a same-cycle read sees the pre-update value.
module branch_predictor_bht
   import cpu_pkg::*;
#(
   parameter int BHT_BITS = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [BHT_BITS-1:0] rd_idx,
   output logic [1:0]          rd_cnt,
   input  logic                upd_en,
   input  logic [BHT_BITS-1:0] upd_idx,
   input  logic                upd_taken
);

   logic [1:0] cnt [0:(1<<BHT_BITS)-1];

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < (1 << BHT_BITS); i++) cnt[i] <= BHT_RESET;
      end else if (upd_en) begin
         if (upd_taken && cnt[upd_idx] != 2'b11)
            cnt[upd_idx] <= cnt[upd_idx] + 2'd1;
         else if (!upd_taken && cnt[upd_idx] != 2'b00)
            cnt[upd_idx] <= cnt[upd_idx] - 2'd1;
      end
   end

   assign rd_cnt = cnt[rd_idx];

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: field decode, register-file addressing, load-use
// stall, static-PC branch prediction, sticky HALT and the ID/EX register.
module decode_stage
   import cpu_pkg::*;
#(
   parameter int BHT_BITS = 4,
   parameter int PC_W     = 8,
   parameter int INSTR_W  = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [INSTR_W-1:0]        if_instruction,
   input  logic [PC_W-1:0]           if_pc,
   input  logic                      if_valid,
   input  logic                      ex_flush,
   input  logic                      ex_resolve,
   input  logic [PC_W-1:0]           ex_resolve_pc,
   input  logic                      ex_taken,
   input  logic                      ex_mem_read,
   input  logic [3:0]                ex_rd,
   input  logic [INSTR_W-1:0]        rf_rdata1,
   input  logic [INSTR_W-1:0]        rf_rdata2,
   output logic [3:0]                rf_raddr1,
   output logic [3:0]                rf_raddr2,
   output logic                      stall,
   output logic                      predict_taken,
   output logic [PC_W-1:0]           branch_target,
   output logic                      halt,
   output logic [3:0]                id_opcode,
   output logic [3:0]                id_rd,
   output logic [INSTR_W-1:0]        id_op1,
   output logic [INSTR_W-1:0]        id_op2,
   output logic signed [INSTR_W-1:0] id_imm,
   output logic [PC_W-1:0]           id_pc,
   output logic                      id_pred,
   output logic                      id_valid
);

   logic [3:0] opcode, fa, fb, fc;
   logic [3:0] rd_d, rs1_d, rs2_d;
   logic       use1, use2;
   logic       hazard, predict_raw, load, squash_p1;
   logic [1:0] bht_cnt;
   logic signed [INSTR_W-1:0] imm_s;
   logic [PC_W-1:0] target;
   logic unused_resolve_hi;

   assign opcode = if_instruction[OPC_HI:OPC_LO];
   assign fa     = if_instruction[FA_HI:FA_LO];
   assign fb     = if_instruction[FB_HI:FB_LO];
   assign fc     = if_instruction[FC_HI:FC_LO];
   assign imm_s  = sext4(fc);

   always_comb begin
      rd_d  = '0;
      rs1_d = '0;
      rs2_d = '0;
      use1  = 1'b0;
      use2  = 1'b0;
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            rd_d = fa; rs1_d = fb; rs2_d = fc; use1 = 1'b1; use2 = 1'b1;
         end
         OP_ADDI, OP_LD: begin
            rd_d = fa; rs1_d = fb; use1 = 1'b1;
         end
         OP_ST, OP_BEQ: begin
            rs1_d = fa; rs2_d = fb; use1 = 1'b1; use2 = 1'b1;
         end
         default: ;
      endcase
   end

   // Only sources the opcode really reads can create a load-use hazard.
   assign hazard = if_valid & ex_mem_read & (ex_rd != 4'd0) &
                   ((use1 & (rs1_d == ex_rd)) | (use2 & (rs2_d == ex_rd)));

   branch_predictor_bht #(.BHT_BITS(BHT_BITS)) u_bht (
      .clk       (clk),
      .reset     (reset),
      .rd_idx    (if_pc[BHT_BITS-1:0]),
      .rd_cnt    (bht_cnt),
      .upd_en    (ex_resolve),
      .upd_idx   (ex_resolve_pc[BHT_BITS-1:0]),
      .upd_taken (ex_taken)
   );
   assign unused_resolve_hi = ^ex_resolve_pc[PC_W-1:BHT_BITS];

   assign target      = if_pc + PC_W'(1) + PC_W'(imm_s);
   assign predict_raw = if_valid & (opcode == OP_BEQ) & bht_cnt[1] & ~hazard &
                        ~squash_p1 & ~ex_flush & ~halt;
   assign load        = if_valid & ~hazard & ~squash_p1 & ~ex_flush & ~halt;

   assign rf_raddr1     = reset ? rs1_d : 4'd0;
   assign rf_raddr2     = reset ? rs2_d : 4'd0;
   assign stall         = reset & hazard;
   assign predict_taken = reset & predict_raw;
   assign branch_target = reset ? target : '0;

   // ID/EX boundary
   always_ff @(posedge clk) begin
      if (!reset) begin
         id_valid  <= 1'b0;
         id_pred   <= 1'b0;
         squash_p1 <= 1'b0;
         halt      <= 1'b0;
         id_opcode <= '0;
         id_rd     <= '0;
         id_op1    <= '0;
         id_op2    <= '0;
         id_imm    <= '0;
         id_pc     <= '0;
      end else begin
         id_valid  <= load;
         id_pred   <= predict_raw;
         squash_p1 <= predict_raw;
         halt      <= halt | (load & (opcode == OP_HALT));
         id_opcode <= opcode;
         id_rd     <= rd_d;
         id_op1    <= rf_rdata1;
         id_op2    <= rf_rdata2;
         id_imm    <= imm_s;
         id_pc     <= if_pc;
      end
   end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second pipeline stage. Consumes instruction/PC_out/valid from the fetch stage.
- Decodes the 16-bit instruction and reads operands from the external register file.
- Detects load-use hazards (drives fetch stall) and makes a 2-bit-counter static-PC branch prediction (drives fetch predict_taken/branch_target).
- Latches HALT and registers the result into the ID/EX pipeline register.

Parameters:
- BHT_BITS, 4, log2 of branch-history-table entries (indexed by PC[BHT_BITS-1:0]).
- PC_W, 8, PC width.
- INSTR_W, 16, instruction width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (port name is reset; asserted when 0).
- if_instruction  in  16  instruction from fetch.
- if_pc  in  8  PC of if_instruction.
- if_valid  in  1  if_instruction is valid.
- ex_flush  in  1  EX mispredict; kill ID contents this cycle.
- ex_resolve  in  1  EX resolved a BEQ this cycle.
- ex_resolve_pc  in  8  PC of the resolved BEQ.
- ex_taken  in  1  actual outcome of the resolved BEQ.
- ex_mem_read  in  1  instruction currently in EX is LD.
- ex_rd  in  4  destination of the instruction in EX.
- rf_rdata1  in  16  regfile read data for rs1.
- rf_rdata2  in  16  regfile read data for rs2.
- rf_raddr1  out  4  combinational regfile read address 1.
- rf_raddr2  out  4  combinational regfile read address 2.
- stall  out  1  combinational; holds fetch.
- predict_taken  out  1  combinational; to fetch.
- branch_target  out  8  combinational; to fetch.
- halt  out  1  registered, sticky.
- id_opcode  out  4  ID/EX opcode.
- id_rd  out  4  ID/EX destination register.
- id_op1  out  16  ID/EX operand 1.
- id_op2  out  16  ID/EX operand 2.
- id_imm  out  16  ID/EX sign-extended immediate.
- id_pc  out  8  ID/EX PC.
- id_pred  out  1  ID/EX: prediction made for this instruction.
- id_valid  out  1  ID/EX: contents valid.

Behaviour:
- Field map: [15:12] opcode, [11:8] rd/rs1, [7:4] rs1/rs2, [3:0] rs2/imm4.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI, 5 LD, 6 ST, 7 BEQ, 8 JMP, F HALT. All others are NOP (id_valid=1, id_rd=0).
- R-type: rd=[11:8], rs1=[7:4], rs2=[3:0].
- ADDI/LD: rd=[11:8], rs1=[7:4], imm=sext(imm4).
- ST/BEQ: rs1=[11:8], rs2=[7:4], imm=sext(imm4).
- JMP: handled entirely in fetch; ID passes it through as a NOP.
- Branch target: target = if_pc + 1 + sext(imm4), mod 256 (wraps: PC FE, offset +3 -> 02).
- rf_raddr1/rf_raddr2 follow the decoded rs1/rs2 fields combinationally.
- Load-use hazard: stall=1 when if_valid & ex_mem_read & ex_rd!=0 & ex_rd matches a source register actually used by the opcode.
  - On stall, the ID/EX register loads a bubble (id_valid=0).
  - The IF/ID inputs are held by fetch.
  - stall is exactly 1 cycle per hazard.
- Prediction: BHT has 2^BHT_BITS 2-bit saturating counters, reset to 01 (weakly not-taken).
  - predict_taken = if_valid & opcode==BEQ & BHT[if_pc]>=2 & ~stall & ~squash & ~ex_flush & ~halt.
  - branch_target is always driven with the computed target.
- squash flag: set the cycle after predict_taken=1, because fetch has already captured the fall-through instruction. While squash=1, the incoming instruction becomes a bubble. squash clears after 1 cycle.
- BHT update on ex_resolve: increment if ex_taken, else decrement; saturate at 00 and 11. A same-cycle read of the same index sees the old value.
- ex_flush: ID/EX loads a bubble, squash clears, predict_taken is suppressed. ex_flush has priority over stall and squash.
- HALT: when a valid, non-squashed HALT is in ID, it passes to ID/EX with id_valid=1, and halt is set the following cycle.
  - Once halt=1, all subsequent ID/EX loads are bubbles.
  - halt clears only on reset; ex_flush does not clear it.
- ID/EX latency: 1 cycle from if_* to id_*.
- Reset (reset==0 at posedge):
  - All id_* = 0; id_valid, halt and squash = 0.
  - All BHT entries = 01.
  - Combinational outputs are forced to 0 while reset is low.
  - Reset mid-operation discards any pending squash or stall.

Decomposition:
- Package cpu_pkg: opcode localparams (OP_ADD..OP_HALT), field-slice constants, BHT reset value 2'b01.
- One sub-module: branch_predictor_bht. Contains the counter array, read port and update port.

Test Plan:
1. Reset low 2 cycles, then feed ADD r1,r2,r3 (0x1123 ignored; opcode 0: 0x0123) at pc 05 -> next cycle id_opcode=0, id_rd=1, rf_raddr1=2, rf_raddr2=3, id_valid=1; all outputs 0 during reset.
2. ex_mem_read=1, ex_rd=2, ID holds ADD reading r2 -> stall=1 for one cycle, id_valid=0 that cycle, ADD issues next cycle. Repeat with ex_rd=0 -> no stall.
3. Train BHT for pc 10 with two ex_resolve taken updates, then BEQ imm=-2 at pc 10 -> predict_taken=1, branch_target=0F; next incoming instruction is squashed (id_valid=0).
4. BEQ at pc FE, imm=+3 -> branch_target=02 (wrap). Counter saturates at 11 after 4 taken updates and at 00 after 4 not-taken updates.
5. ex_flush concurrent with stall and a predicted BEQ -> id_valid=0, predict_taken=0, squash cleared.
6. HALT (0xF000) valid -> id_valid=1 with opcode F, halt=1 next cycle; later instructions are bubbles; reset clears halt.
